if_fetch_pair: RTL

IF_FETCH_PAIR -- requirements
Module: if_fetch_pair

---
 rtl/if_fetch_pkg.sv | 21 ++
 rtl/if_fetch_perf.sv | 30 +++
 rtl/if_fetch_pair.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the paired instruction fetch stage.
// Holds the FSM state encoding, the pair PC step and the NOP word.
package if_fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_HOLD  = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  localparam logic [31:0] PC_STEP  = 32'd8;
  localparam logic [31:0] NOP_WORD = 32'h0;

  function automatic logic [31:0] align_pc(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_perf.sv
// Saturating fetch performance counters (stall cycles, discarded pairs).
// Ports: clk, reset, i_stall, i_flush -> o_stall_cnt[31:0], o_flush_cnt[15:0].
module if_fetch_perf (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_stall,
  input  logic        i_flush,
  output logic [31:0] o_stall_cnt,
  output logic [15:0] o_flush_cnt
);

  logic [31:0] r_stall;
  logic [15:0] r_flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall <= '0;
      r_flush <= '0;
    end else begin
      if (i_stall && (r_stall != '1))
        r_stall <= r_stall + 32'd1;
      if (i_flush && (r_flush != '1))
        r_flush <= r_flush + 16'd1;
    end
  end

  assign o_stall_cnt = r_stall;
  assign o_flush_cnt = r_flush;

endmodule

// File: rtl/if_fetch_pair.sv
// Paired instruction fetch: requests two words at pc, presents them to IF/ID.
// Ports: clk, reset, IF_ID_enable, redirect_valid/pc, imem_req/addr/ack/rdata_0/1,
// PC_4, Instrucction, PC_8, Instrucction_2, fetch_valid.
// Macro IF_FETCH_PERF_EN adds perf_stall_cnt / perf_flush_cnt outputs.
module if_fetch_pair
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          IMEM_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IF_ID_enable,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata_0,
  input  logic [31:0] imem_rdata_1,
  output logic [31:0] PC_4,
  output logic [31:0] Instrucction,
  output logic [31:0] PC_8,
  output logic [31:0] Instrucction_2,
`ifdef IF_FETCH_PERF_EN
  output logic [31:0] perf_stall_cnt,
  output logic [15:0] perf_flush_cnt,
`endif
  output logic        fetch_valid
);

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_addr;
  logic        r_req;
  logic        r_valid;
  logic [31:0] r_i0;
  logic [31:0] r_i1;
  logic [31:0] r_pc4;
  logic [31:0] r_pc8;

  logic [31:0] w_rpc;
  logic [31:0] w_pc_n;
  logic [31:0] w_pc_step;
  logic        w_unused;

  assign w_rpc     = align_pc(redirect_pc);
  assign w_pc_n    = redirect_valid ? w_rpc : r_pc;
  assign w_pc_step = r_pc + PC_STEP;
  assign w_unused  = ^{IMEM_TIMEOUT[0], redirect_pc[1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_addr  <= '0;
      r_req   <= 1'b0;
      r_valid <= 1'b0;
      r_i0    <= NOP_WORD;
      r_i1    <= NOP_WORD;
      r_pc4   <= '0;
      r_pc8   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_pc    <= w_pc_n;
          r_addr  <= w_pc_n;
          r_req   <= 1'b1;
          r_state <= S_REQ;
        end
        S_REQ: begin
          if (redirect_valid) begin
            r_pc <= w_rpc;
            // Acked data belongs to the old path; reissue at once.
            if (imem_ack)
              r_addr <= w_rpc;
            else
              r_state <= S_FLUSH;
          end else if (imem_ack) begin
            r_i0    <= imem_rdata_0;
            r_i1    <= imem_rdata_1;
            r_pc4   <= r_pc + 32'd4;
            r_pc8   <= r_pc + 32'd8;
            r_valid <= 1'b1;
            r_req   <= 1'b0;
            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (redirect_valid || !IF_ID_enable) begin
            r_valid <= 1'b0;
            r_i0    <= NOP_WORD;
            r_i1    <= NOP_WORD;
            r_pc4   <= '0;
            r_pc8   <= '0;
            r_pc    <= redirect_valid ? w_rpc : w_pc_step;
            r_addr  <= redirect_valid ? w_rpc : w_pc_step;
            r_req   <= 1'b1;
            r_state <= S_REQ;
          end
        end
        S_FLUSH: begin
          // Old request stays on the bus until its ack drains it.
          r_pc <= w_pc_n;
          if (imem_ack) begin
            r_addr  <= w_pc_n;
            r_state <= S_REQ;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign imem_req       = r_req;
  assign imem_addr      = r_addr;
  assign fetch_valid    = r_valid;
  assign Instrucction   = r_i0;
  assign Instrucction_2 = r_i1;
  assign PC_4           = r_pc4;
  assign PC_8           = r_pc8;

`ifdef IF_FETCH_PERF_EN
  logic w_stall;
  logic w_flush;

  assign w_stall = (r_state == S_HOLD) && IF_ID_enable;
  assign w_flush = ((r_state == S_REQ) && redirect_valid && imem_ack)
                 || ((r_state == S_FLUSH) && imem_ack)
                 || ((r_state == S_HOLD) && redirect_valid);

  if_fetch_perf u_perf (
    .clk         (clk),
    .reset       (reset),
    .i_stall     (w_stall),
    .i_flush     (w_flush),
    .o_stall_cnt (perf_stall_cnt),
    .o_flush_cnt (perf_flush_cnt)
  );
`endif

endmodule
